// File: rtl/lzc_norm_arb_if.sv
// lzc_norm_arb_if: request/response bundle shared by the normalizer and its requesters.
// slave  = normalizer side (takes req/req_data/out_ready, drives ack and result).
// master = requesters plus result consumer.
interface lzc_norm_arb_if #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4
);
  localparam int SW = $clog2(WIDTH) + 1;
  localparam int IW = $clog2(NREQ);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ack;
  logic                  out_valid;
  logic                  out_ready;
  logic [IW-1:0]         out_id;
  logic [SW-1:0]         out_shift;
  logic [WIDTH-1:0]      out_norm;
  logic                  out_zero;
  modport slave (
    input  req, req_data, out_ready,
    output req_ack, out_valid, out_id, out_shift, out_norm, out_zero
  );
  modport master (
    output req, req_data, out_ready,
    input  req_ack, out_valid, out_id, out_shift, out_norm, out_zero
  );
endinterface

// File: rtl/lzc_norm_arb.sv
// lzc_norm_arb: shared leading-zero normalizer arbitrating NREQ requesters onto one LZC/shift datapath.
// Ports: clk, reset_n (async active-low), ifc (lzc_norm_arb_if.slave: req/req_data/req_ack in,
//        out_valid/out_ready/out_id/out_shift/out_norm/out_zero result handshake).
// LZC_NORM_ARB_RR_EN: defined = round-robin arbitration, undefined = fixed priority (lowest index).
module lzc_norm_arb #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  lzc_norm_arb_if.slave ifc
);
  localparam int SW = $clog2(WIDTH) + 1;
  localparam int IW = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, COUNT, SHIFT, RESP} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d, norm_q, norm_d;
  logic [IW-1:0]    id_q, id_d, oid_q, oid_d, win;
  logic [SW-1:0]    cnt_q, cnt_d, shift_q, shift_d, lzc;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic             valid_q, valid_d, zero_q, zero_d, grant;
  logic [WIDTH-1:0] ops [NREQ];
  for (genvar i = 0; i < NREQ; i++) begin : g_op
    assign ops[i] = ifc.req_data[i*WIDTH +: WIDTH];
  end
  // Ascending scan: the highest set bit is written last and wins.
  always_comb begin
    lzc = SW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) if (data_q[i]) lzc = SW'(WIDTH - 1 - i);
  end
`ifdef LZC_NORM_ARB_RR_EN
  logic [IW-1:0] last_q;
  int            rr_t;
  // Scan from the far end of the search order so the first requester after last is written last.
  always_comb begin
    win  = '0;
    rr_t = 0;
    for (int k = NREQ; k >= 1; k--) begin
      rr_t = (int'(last_q) + k) % NREQ;
      if (ifc.req[IW'(rr_t)]) win = IW'(rr_t);
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_q <= IW'(NREQ - 1);
    else if (grant) last_q <= win;
  end
`else
  always_comb begin
    win = '0;
    for (int k = NREQ - 1; k >= 0; k--) if (ifc.req[IW'(k)]) win = IW'(k);
  end
`endif
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    ack_d   = '0;
    valid_d = valid_q;
    oid_d   = oid_q;
    shift_d = shift_q;
    norm_d  = norm_q;
    zero_d  = zero_q;
    grant   = 1'b0;
    case (state_q)
      IDLE: grant = |ifc.req;
      COUNT: begin
        cnt_d   = lzc;
        state_d = SHIFT;
      end
      SHIFT: begin
        shift_d = cnt_q;
        zero_d  = cnt_q[SW-1];
        norm_d  = cnt_q[SW-1] ? '0 : data_q << cnt_q[SW-2:0];
        oid_d   = id_q;
        valid_d = 1'b1;
        state_d = RESP;
      end
      RESP: if (ifc.out_ready) begin
        valid_d = 1'b0;
        grant   = |ifc.req;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // The ack pulse lands in the COUNT cycle, after the operand has been captured.
    if (grant) begin
      data_d  = ops[win];
      id_d    = win;
      ack_d   = NREQ'(1) << win;
      state_d = COUNT;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      valid_q <= 1'b0;
      oid_q   <= '0;
      shift_q <= '0;
      norm_q  <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
      oid_q   <= oid_d;
      shift_q <= shift_d;
      norm_q  <= norm_d;
      zero_q  <= zero_d;
    end
  end
  assign ifc.req_ack   = ack_q;
  assign ifc.out_valid = valid_q;
  assign ifc.out_id    = oid_q;
  assign ifc.out_shift = shift_q;
  assign ifc.out_norm  = norm_q;
  assign ifc.out_zero  = zero_q;
endmodule

// File: doc/lzc_norm_arb.md
Name: lzc_norm_arb

Overview:
- Shared leading-zero normalizer. Arbitrates between NREQ requesters for one leading-zero-count datapath, then left-shifts the winning operand so its MSB is 1.
- Returns the shift count, the normalized value and the requester id over a valid/ready response port.
- Sits ahead of the fixed-point reciprocal/distance logic in the ray-casting pipeline, so the per-column tracers share a single counter/shifter.

Parameters:
- WIDTH, 16, operand width in bits; ≥4, power of two.
- NREQ, 4, number of requesters; ≥2.

Ports:
- clk  in  1  system clock; everything is on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester request level.
- req_data  in  NREQ*WIDTH  operands; requester k uses bits [k*WIDTH +: WIDTH].
- req_ack  out  NREQ  one-hot, one-cycle grant/consume pulse.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_id  out  $clog2(NREQ)  index of the requester that owns the result.
- out_shift  out  $clog2(WIDTH)+1  leading-zero count, 0..WIDTH.
- out_norm  out  WIDTH  operand << out_shift.
- out_zero  out  1  operand was all zeroes.

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE.
  - req_ack, out_valid, out_id, out_shift, out_norm, out_zero all 0.
  - Round-robin pointer last=NREQ-1, so requester 0 wins first.
  - Reset mid-operation discards the in-flight operand; no ack or result is produced for it.
- States: IDLE, COUNT, SHIFT, RESP.
- IDLE:
  - If |req, select winner w, latch data_q=req_data[w] and id_q=w, go to COUNT.
  - req_ack[w]=1 during the COUNT cycle only.
  - Otherwise stay in IDLE.
- COUNT:
  - Compute the LZC of data_q, register cnt_q.
  - allzero gives cnt_q=WIDTH; otherwise cnt_q = the number of zeroes above the highest set bit.
  - Go to SHIFT.
- SHIFT:
  - norm_q = data_q << cnt_q[$clog2(WIDTH)-1:0]; force 0 when allzero.
  - Load out_shift, out_norm, out_zero and out_id; set out_valid=1; go to RESP.
- RESP:
  - Outputs hold stable while out_valid=1 && !out_ready.
  - On out_valid && out_ready: clear out_valid. If |req, arbitrate immediately (same rules as IDLE) and go to COUNT; otherwise go to IDLE.
- Latency: req sampled high in IDLE → out_valid 3 cycles later.
- Throughput: one result per 3 cycles when out_ready is held high and requests are continuous.
- Requester contract:
  - Hold req and req_data stable until req_ack is sampled high.
  - Deassert req in the cycle after the ack unless another operand is pending.
  - req_data may change freely after the ack.
- The block never issues a second ack before the previous result has been accepted.
- No arbitration occurs in COUNT or SHIFT; requests raised there wait.
- Pointer last updates to w on every grant only.
- out_shift MSB set ⇔ out_zero.
- out_norm[WIDTH-1]=1 whenever !out_zero.

Optional Feature:
- Macro LZC_NORM_ARB_RR_EN.
- Defined: round-robin arbitration. Search indices last+1, last+2, … modulo NREQ; the first requesting index wins.
- Undefined: fixed priority, lowest requesting index wins. Pointer logic is removed; out_id and ack behaviour are otherwise identical.

Test Plan (WIDTH=16, NREQ=4, out_ready=1 unless noted):
- req[0]=1, data 0x0100 in IDLE at cycle 0 → req_ack=0001 at cycle 1; out_valid at cycle 3 with out_shift=7, out_norm=0x8000, out_zero=0, out_id=0.
- Single requests with data 0x8000, 0x0001, 0x0000 → shift/norm/zero = 0/0x8000/0, 15/0x8000/0, 16/0x0000/1.
- All four req held continuously:
  - RR_EN defined → grant order 0,1,2,3,0,1; results 3 cycles apart; out_id matches.
  - RR_EN undefined → grants 0,0,0.
- out_ready=0 for 5 cycles while a result is pending and req[2]=1 → outputs frozen, req_ack stays 0. Raise out_ready → result accepted, req_ack[2] next cycle, new result 3 cycles after the accept.
- Requests raised during COUNT/SHIFT → no ack until after RESP accept; no result lost or duplicated (scoreboard of ids and data).
- reset_n pulsed low while in SHIFT → all outputs 0 immediately; after release the next grant goes to requester 0 (RR_EN); no result for the aborted operand.
